// File: rtl/fp_div_if.sv
// Handshake bundle for fp_div_iter: operand pair in, quotient out.
// With FPU_DIV_FLAGS_EN defined, the bundle also carries o_flags {NV,DZ,OF,UF,NX}.
interface fp_div_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_x;
  logic [31:0] i_y;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;
`ifdef FPU_DIV_FLAGS_EN
  logic [4:0]  o_flags;

  modport slave  (input  i_valid, i_x, i_y, i_ready,
                  output o_ready, o_valid, o_result, o_busy, o_flags);
  modport master (output i_valid, i_x, i_y, i_ready,
                  input  o_ready, o_valid, o_result, o_busy, o_flags);
`else
  modport slave  (input  i_valid, i_x, i_y, i_ready,
                  output o_ready, o_valid, o_result, o_busy);
  modport master (output i_valid, i_x, i_y, i_ready,
                  input  o_ready, o_valid, o_result, o_busy);
`endif
endinterface

// File: rtl/fp_div_iter.sv
// Multi-cycle binary32 divider X/Y: radix-2 restoring, one quotient bit per cycle, RNE.
// Optional macro FPU_DIV_FLAGS_EN adds o_flags {NV,DZ,OF,UF,NX}; o_result is identical either way.
module fp_div_iter #(
  parameter int          QBITS     = 26,
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  fp_div_if.slave bus
);
  localparam int CW = $clog2(QBITS);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        x_q, x_d, y_q, y_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        sig_y_q, sig_y_d;
  logic [24:0]        rem_q, rem_d;
  logic [QBITS-1:0]   q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [31:0]        result_q, result_d;
`ifdef FPU_DIV_FLAGS_EN
  logic [4:0]         flags_q, flags_d;
  logic               snan;
`endif

  logic [7:0]         ex, ey;
  logic [22:0]        mx, my;
  logic               zx, zy, infx, infy, nanx, nany;
  logic signed [25:0] trial;
  logic [32:0]        em;

  // Normalise the raw quotient, apply RNE and return {exponent, fraction}.
  function automatic logic [32:0] rnd_em(input logic [QBITS-1:0] q, input logic sticky,
                                         input logic signed [9:0] e_in);
    logic [QBITS-1:0]  qn;
    logic signed [9:0] e;
    logic [24:0]       m;
    logic              inc;
    qn  = q[QBITS-1] ? q : (q << 1);
    e   = q[QBITS-1] ? e_in : e_in - 10'sd1;
    inc = qn[QBITS-25] & ((|qn[QBITS-26:0]) | sticky | qn[QBITS-24]);
    m   = {1'b0, qn[QBITS-1 -: 24]} + 25'(inc);
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    return {e, m[22:0]};
  endfunction

  function automatic logic [31:0] pack_res(input logic sgn, input logic [32:0] em_in);
    logic signed [9:0] e;
    e = em_in[32:23];
    if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
    if (e <= 10'sd0)   return {sgn, 31'd0};
    return {sgn, e[7:0], em_in[22:0]};
  endfunction

`ifdef FPU_DIV_FLAGS_EN
  function automatic logic [4:0] round_flags(input logic [QBITS-1:0] q, input logic sticky,
                                             input logic signed [9:0] e);
    logic [QBITS-1:0] qn;
    logic             nx;
    qn = q[QBITS-1] ? q : (q << 1);
    nx = (|qn[QBITS-25:0]) | sticky;
    if (e >= 10'sd255) return 5'b00101;
    if (e <= 10'sd0)   return 5'b00011;
    return {4'b0000, nx};
  endfunction

  assign snan = (nanx & ~mx[22]) | (nany & ~my[22]);
`endif

  assign ex    = x_q[30:23];
  assign ey    = y_q[30:23];
  assign mx    = x_q[22:0];
  assign my    = y_q[22:0];
  assign zx    = (ex == 8'd0);
  assign zy    = (ey == 8'd0);
  assign infx  = (ex == 8'hFF) && (mx == 23'd0);
  assign infy  = (ey == 8'hFF) && (my == 23'd0);
  assign nanx  = (ex == 8'hFF) && (mx != 23'd0);
  assign nany  = (ey == 8'hFF) && (my != 23'd0);
  assign trial = $signed({1'b0, rem_q}) - $signed({2'b00, sig_y_q});
  assign em    = rnd_em(q_q, |rem_q, exp_q);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_y_d  = sig_y_q;
    rem_d    = rem_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    result_d = result_q;
`ifdef FPU_DIV_FLAGS_EN
    flags_d  = flags_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid && ready_q) begin
          x_d     = bus.i_x;
          y_d     = bus.i_y;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
`ifdef FPU_DIV_FLAGS_EN
          flags_d = 5'd0;
`endif
        end
      end
      S_UNPACK: begin
        sign_d = x_q[31] ^ y_q[31];
        // Special operands short-circuit straight to DONE, in priority order.
        if (nanx || nany) begin
          result_d = CANON_NAN;
`ifdef FPU_DIV_FLAGS_EN
          flags_d  = {snan, 4'b0000};
`endif
        end else if ((infx && infy) || (zx && zy)) begin
          result_d = CANON_NAN;
`ifdef FPU_DIV_FLAGS_EN
          flags_d  = 5'b10000;
`endif
        end else if (infx || zy) begin
          result_d = {sign_d, 8'hFF, 23'd0};
`ifdef FPU_DIV_FLAGS_EN
          flags_d  = {1'b0, zy & ~infx, 3'b000};
`endif
        end else if (zx || infy) begin
          result_d = {sign_d, 31'd0};
        end
        if (nanx || nany || infx || infy || zx || zy) begin
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          sig_y_d = {1'b1, my};
          rem_d   = {2'b01, mx};
          exp_d   = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;
          q_d     = '0;
          cnt_d   = CW'(QBITS - 1);
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (!trial[25]) begin
          q_d   = {q_q[QBITS-2:0], 1'b1};
          rem_d = trial[24:0] << 1;
        end else begin
          q_d   = {q_q[QBITS-2:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        result_d = pack_res(sign_q, em);
`ifdef FPU_DIV_FLAGS_EN
        flags_d  = round_flags(q_q, |rem_q, $signed(em[32:23]));
`endif
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_y_q  <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
`ifdef FPU_DIV_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_y_q  <= sig_y_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
`ifdef FPU_DIV_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_result = result_q;
`ifdef FPU_DIV_FLAGS_EN
  assign bus.o_flags  = flags_q;
`endif

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed vectors, randomized ops against an
// exact-integer reference divider, backpressure and mid-operation reset.
module tb_fp_div_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  fp_div_if bus();

  fp_div_iter dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: classify, then exact integer quotient with generic round-to-nearest-even.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [4:0] f, output bit sp);
    logic s, zx, zy, infx, infy, nanx, nany, snan;
    longint unsigned num, den, q, mant, rb, half;
    int e, sh;
    bit exact, up, inexact;
    s    = x[31] ^ y[31];
    zx   = (x[30:23] == 8'd0);
    zy   = (y[30:23] == 8'd0);
    infx = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    infy = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    nanx = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    nany = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    snan = (nanx && !x[22]) || (nany && !y[22]);
    sp = 1'b1;
    f  = 5'd0;
    if (nanx || nany) begin
      r = 32'h7FC00000; f = snan ? 5'b10000 : 5'b00000;
    end else if ((infx && infy) || (zx && zy)) begin
      r = 32'h7FC00000; f = 5'b10000;
    end else if (infx || zy) begin
      r = {s, 8'hFF, 23'd0}; f = (zy && !infx) ? 5'b01000 : 5'b00000;
    end else if (zx || infy) begin
      r = {s, 31'd0};
    end else begin
      sp    = 1'b0;
      num   = longint'({1'b1, x[22:0]}) << 26;
      den   = longint'({1'b1, y[22:0]});
      q     = num / den;
      exact = ((num % den) == 0);
      e     = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (q >= (64'd1 << 26)) sh = 3;
      else begin sh = 2; e = e - 1; end
      mant    = q >> sh;
      rb      = q & ((64'd1 << sh) - 1);
      half    = 64'd1 << (sh - 1);
      up      = (rb > half) || ((rb == half) && (!exact || mant[0]));
      inexact = (rb != 0) || !exact;
      mant    = mant + (up ? 64'd1 : 64'd0);
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
      if (e >= 255)    begin r = {s, 8'hFF, 23'd0}; f = 5'b00101; end
      else if (e <= 0) begin r = {s, 31'd0};        f = 5'b00011; end
      else begin
        r = {s, e[7:0], mant[22:0]};
        f = {4'b0000, inexact};
      end
    end
  endtask

  // Issue one operation, return result, flags and accept-to-valid latency (-1 if never ready).
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output logic [4:0] fl, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      lat = -1; res = 'x; fl = 'x;
      return;
    end
    bus.i_ready = 1'b1;
    bus.i_x     = x;
    bus.i_y     = y;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    res = bus.o_result;
`ifdef FPU_DIV_FLAGS_EN
    fl = bus.o_flags;
`else
    fl = 5'd0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.o_ready !== 1'b1)     begin bad++; $display("FAIL reset_ready got=%b want=1", bus.o_ready); end
    total++; if (bus.o_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
    total++; if (bus.o_busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", bus.o_busy); end
    total++; if (bus.o_result !== 32'd0)   begin bad++; $display("FAIL reset_result got=%h want=0", bus.o_result); end
`ifdef FPU_DIV_FLAGS_EN
    total++; if (bus.o_flags !== 5'd0)     begin bad++; $display("FAIL reset_flags got=%b want=0", bus.o_flags); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] tx[13], ty[13], tr[13];
    logic [4:0]  tf[13];
    bit          tsp[13];
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    tx  = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800001, 32'h7FC00000,
            32'h7F000000, 32'h00800000, 32'h7F800000, 32'h00400000, 32'h3F800000, 32'hC0C00000};
    ty  = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800000,
            32'h00800000, 32'h7F000000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h40000000};
    tr  = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
            32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h00000000, 32'h00000000, 32'hC0400000};
    tf  = '{5'b00000, 5'b00001, 5'b01000, 5'b01000, 5'b10000, 5'b10000, 5'b00000,
            5'b00101, 5'b00011, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
    tsp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      do_op(tx[i], ty[i], res, fl, lat);
      total++;
      if (res !== tr[i]) begin
        bad++; $display("FAIL directed_result[%0d] %h/%h got=%h want=%h", i, tx[i], ty[i], res, tr[i]);
      end
      total++;
      if (tsp[i] ? !(lat >= 1 && lat <= 2) : (lat != 28)) begin
        bad++; $display("FAIL directed_latency[%0d] got=%0d want=%0s", i, lat, tsp[i] ? "<=2" : "28");
      end
`ifdef FPU_DIV_FLAGS_EN
      total++;
      if (fl !== tf[i]) begin
        bad++; $display("FAIL directed_flags[%0d] got=%b want=%b", i, fl, tf[i]);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, res, er;
    logic [4:0]  fl, ef;
    bit          sp;
    int          lat, kind;
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      y = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        x[30:23] = 8'($urandom_range(100, 154));
        y[30:23] = 8'($urandom_range(100, 154));
      end else if (kind == 6) begin
        if ($urandom_range(0, 1) == 1) x[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        else                           y[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      end
      model(x, y, er, ef, sp);
      do_op(x, y, res, fl, lat);
      total++;
      if (res !== er) begin
        bad++; $display("FAIL random_result %h/%h got=%h want=%h", x, y, res, er);
      end
      total++;
      if (sp ? !(lat >= 1 && lat <= 2) : (lat != 28)) begin
        bad++; $display("FAIL random_latency %h/%h got=%0d special=%0d", x, y, lat, sp);
      end
`ifdef FPU_DIV_FLAGS_EN
      total++;
      if (fl !== ef) begin
        bad++; $display("FAIL random_flags %h/%h got=%b want=%b", x, y, fl, ef);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_x     = 32'h40C00000;
    bus.i_y     = 32'h40000000;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    n = 0;
    while (bus.o_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    total++; if (n != 28) begin bad++; $display("FAIL bp_first_latency got=%0d want=28", n); end
    bus.i_x     = 32'h3F800000;
    bus.i_y     = 32'h40400000;
    bus.i_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== 32'h40400000 || bus.o_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] valid=%b result=%h ready=%b want 1/40400000/0",
                        c, bus.o_valid, bus.o_result, bus.o_ready);
      end
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release valid=%b ready=%b want 0/1", bus.o_valid, bus.o_ready);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept ready=%b want=0", bus.o_ready); end
    n = 0;
    while (bus.o_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    total++; if (n != 28) begin bad++; $display("FAIL bp_second_latency got=%0d want=28", n); end
    total++;
    if (bus.o_result !== 32'h3EAAAAAB) begin
      bad++; $display("FAIL bp_second_result got=%h want=3eaaaaab", bus.o_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_divide();
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    @(negedge clk);
    bus.i_ready = 1'b1;
    bus.i_x     = 32'h40C00000;
    bus.i_y     = 32'h40000000;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (11) @(negedge clk);
    total++;
    if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL mid_busy busy=%b ready=%b valid=%b want 1/0/0", bus.o_busy, bus.o_ready, bus.o_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_result !== 32'd0) begin
      bad++; $display("FAIL mid_reset ready=%b valid=%b busy=%b result=%h want 1/0/0/0",
                      bus.o_ready, bus.o_valid, bus.o_busy, bus.o_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h40C00000, 32'h40000000, res, fl, lat);
    total++; if (res !== 32'h40400000) begin bad++; $display("FAIL post_reset_result got=%h want=40400000", res); end
    total++; if (lat != 28) begin bad++; $display("FAIL post_reset_latency got=%0d want=28", lat); end
`ifdef FPU_DIV_FLAGS_EN
    total++; if (fl !== 5'd0) begin bad++; $display("FAIL post_reset_flags got=%b want=0", fl); end
`endif
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_x     = 32'd0;
    bus.i_y     = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_divide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
